// File: rtl/bsg_link_upstream_out.sv
// Transmit side of the off-chip link: serializes core words into io beats
// (LSB first) under credit-based flow control fed by decimated tokens.
module bsg_link_upstream_out #(
  parameter int WIDTH_IN         = 32,
  parameter int WIDTH_OUT        = 8,
  parameter int BEATS            = 4,
  parameter int CREDITS          = 16,
  parameter int TOKEN_DECIMATION = 4,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH_IN-1:0]            core_data_i,
  input  logic                           core_valid_i,
  output logic                           core_ready_o,
  output logic [WIDTH_OUT-1:0]           io_data_o,
  output logic                           io_valid_o,
  input  logic                           token_i,
  output logic [$clog2(CREDITS+1)-1:0]   credits_o,
  output logic                           busy_o,
  output logic                           credit_overflow_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW = $clog2(CREDITS + TOKEN_DECIMATION + 1) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [WIDTH_IN-1:0]    shreg_q, shreg_d;
  logic [WIDTH_OUT-1:0]   data_q, data_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tok_edge;
  logic                   last_beat;
  logic                   ready;
  logic                   accept;
  logic [SW-1:0]          sum;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign ready     = !rst && (credits_q != '0) && ((state_q == IDLE) || last_beat);
  assign accept    = core_valid_i && ready;
  assign tok_edge  = sync_q[SYNC_STAGES-1] && !prev_q;

  // token_i is asynchronous; only the last stage feeds the edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], token_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Serializer: the beat on io_data_o is registered; shreg holds the bytes still to go
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
          data_d  = core_data_i[WIDTH_OUT-1:0];
          shreg_d = core_data_i >> WIDTH_OUT;
        end
      end
      SEND: begin
        if (last_beat) begin
          if (accept) begin
            beat_d  = '0;
            data_d  = core_data_i[WIDTH_OUT-1:0];
            shreg_d = core_data_i >> WIDTH_OUT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d  = beat_q + 1'b1;
          data_d  = shreg_q[WIDTH_OUT-1:0];
          shreg_d = shreg_q >> WIDTH_OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    ovf_d     = ovf_q;
    sum       = SW'(credits_q) + (tok_edge ? SW'(TOKEN_DECIMATION) : SW'(0)) - SW'(accept);
    if (sum > SW'(CREDITS)) begin
      credits_d = CW'(CREDITS);
      ovf_d     = 1'b1;
    end else begin
      credits_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      credits_q <= CW'(CREDITS);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      credits_q <= credits_d;
      ovf_q     <= ovf_d;
    end
  end

  assign core_ready_o      = ready;
  assign io_valid_o        = !rst && (state_q == SEND);
  assign busy_o            = !rst && (state_q == SEND);
  assign io_data_o         = rst ? '0 : data_q;
  assign credits_o         = credits_q;
  assign credit_overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_link_upstream_out.sv
// Bench for bsg_link_upstream_out: directed plan steps plus random traffic,
// checked every cycle against a byte-queue / credit-count reference model.
module tb_bsg_link_upstream_out;

  logic        clk;
  logic        rst;
  logic [31:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        token_i;
  logic [4:0]  credits_o;
  logic        busy_o;
  logic        credit_overflow_o;

  bsg_link_upstream_out #(
    .WIDTH_IN(32), .WIDTH_OUT(8), .BEATS(4), .CREDITS(16),
    .TOKEN_DECIMATION(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .io_data_o(io_data_o), .io_valid_o(io_valid_o),
    .token_i(token_i), .credits_o(credits_o), .busy_o(busy_o),
    .credit_overflow_o(credit_overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: bytes still owed on the wire, credit count, token history
  byte unsigned q[$];
  int  m_cred;
  bit  m_ovf;
  bit  h0, h1, h2;
  bit  m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cred = 16;
    m_ovf  = 1'b0;
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    m_acc  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance model at posedge
  task automatic tick(input bit v, input logic [31:0] d, input bit t, input bit r);
    bit exp_ready;
    bit exp_valid;
    bit tok;
    int n;
    core_valid_i = v;
    core_data_i  = d;
    token_i      = t;
    rst          = r;
    #1;
    exp_valid = !r && (q.size() > 0);
    exp_ready = !r && (m_cred > 0) && (q.size() <= 1);
    chk("core_ready", core_ready_o, exp_ready);
    chk("io_valid", io_valid_o, exp_valid);
    chk("busy", busy_o, exp_valid);
    if (r) chk("io_data_rst", io_data_o, 0);
    else if (exp_valid) chk("io_data", io_data_o, q[0]);
    chk("credits", credits_o, m_cred);
    chk("overflow", credit_overflow_o, m_ovf);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_acc = v && exp_ready;
      tok   = h1 && !h2;
      if (q.size() > 0) void'(q.pop_front());
      if (m_acc) for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
      n = m_cred - (m_acc ? 1 : 0) + (tok ? 4 : 0);
      if (n > 16) begin
        n = 16;
        m_ovf = 1'b1;
      end
      m_cred = n;
      h2 = h1; h1 = h0; h0 = t;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    do begin
      tick(1'b1, w, 1'b0, 1'b0);
      n++;
    end while (!m_acc && n < 200);
    vectors++;
    assert (m_acc) else begin
      miscompares++;
      $error("FAIL send_timeout observed=%0d expected=accept word=%0h", n, w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    bit tok_r;
    bit v_r;
    bit r_r;
    rst = 1'b1; core_valid_i = 1'b0; core_data_i = '0; token_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single word, valid for one cycle
    tick(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0);
    idle(6);
    chk("single_credits", credits_o, 15);

    // Back-to-back stream with valid held
    do_reset();
    send(32'h03020100);
    send(32'h07060504);
    idle(6);

    // Credit exhaustion and recovery by one token
    do_reset();
    for (int i = 0; i < 16; i++) send($urandom);
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h17171717, 1'b0, 1'b0);
    chk("exhausted_credits", credits_o, 0);
    chk("exhausted_ready", core_ready_o, 0);
    tick(1'b1, 32'h17171717, 1'b1, 1'b0);
    send(32'h17171717);
    idle(6);

    // Accept coinciding with a token edge at credits=2
    do_reset();
    for (int i = 0; i < 14; i++) send($urandom);
    idle(8);
    chk("pre_sim_credits", credits_o, 2);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    chk("sim_accept_edge", credits_o, 5);
    idle(6);

    // Saturation and sticky overflow
    do_reset();
    send(32'h11111111);
    send(32'h22222222);
    idle(8);
    tick(1'b0, '0, 1'b1, 1'b0);
    idle(4);
    chk("ovf_credits", credits_o, 16);
    chk("ovf_flag", credit_overflow_o, 1);
    tick(1'b0, '0, 1'b1, 1'b0);
    idle(4);
    chk("ovf_sticky", credit_overflow_o, 1);
    do_reset();
    chk("ovf_cleared", credit_overflow_o, 0);

    // Reset at beat 2 of a word, then a fresh word
    send(32'h44332211);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("midreset_valid", io_valid_o, 0);
    chk("midreset_credits", credits_o, 16);
    idle(3);
    send(32'h88776655);
    idle(6);

    // Random traffic with random token toggling and occasional reset
    tok_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) tok_r = ~tok_r;
      if (r_r) tok_r = 1'b0;
      v_r = ($urandom_range(0, 3) != 0);
      tick(v_r, $urandom, tok_r, r_r);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
